// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - Runs one- and two-word operations through an external combinational ALU
module alu_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_fs,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0] req_a_hi,
    input  logic [WIDTH-1:0] req_b_hi,
    input  logic [1:0]       req_cin_sel,
    input  logic             req_set_flags,
    input  logic             req_wide,
    output logic [4:0]       alu_fs,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic [3:0]       alu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_lo,
    output logic [WIDTH-1:0] rsp_hi,
    output logic [3:0]       rsp_status,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC_LO = 2'd1,
        EXEC_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_hi_q;
    logic [WIDTH-1:0] b_hi_q;
    logic             set_flags_q;
    logic             wide_q;
    logic             z_lo_q;

    logic             cin_d;
    logic             wide_d;
    logic [3:0]       hi_status_d;

    always_comb begin
        cin_d = 1'b0;
        case (req_cin_sel)
            2'b01:   cin_d = 1'b1;
            2'b10:   cin_d = flags[1];
            default: cin_d = 1'b0;
        endcase
    end

    // Shift/zero functions (fs[4]=1) have no upper word to chain into.
    assign wide_d      = req_wide & ~req_fs[4];
    assign hi_status_d = {z_lo_q & alu_status[3], alu_status[2:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_lo      <= '0;
            rsp_hi      <= '0;
            rsp_status  <= '0;
            flags       <= '0;
            alu_fs      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_cin     <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            set_flags_q <= 1'b0;
            wide_q      <= 1'b0;
            z_lo_q      <= 1'b0;
        end else if (flush) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        alu_fs      <= req_fs;
                        alu_a       <= req_a;
                        alu_b       <= req_b;
                        alu_cin     <= cin_d;
                        a_hi_q      <= req_a_hi;
                        b_hi_q      <= req_b_hi;
                        set_flags_q <= req_set_flags;
                        wide_q      <= wide_d;
                        req_ready   <= 1'b0;
                        state_q     <= EXEC_LO;
                    end
                end
                EXEC_LO: begin
                    rsp_lo <= alu_result;
                    z_lo_q <= alu_status[3];
                    if (wide_q) begin
                        // The low-word carry chains into the upper beat via alu_cin.
                        alu_a   <= a_hi_q;
                        alu_b   <= b_hi_q;
                        alu_cin <= alu_cout;
                        state_q <= EXEC_HI;
                    end else begin
                        rsp_hi     <= '0;
                        rsp_status <= alu_status;
                        if (set_flags_q) begin
                            flags <= alu_status;
                        end
                        rsp_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                EXEC_HI: begin
                    rsp_hi     <= alu_result;
                    rsp_status <= hi_status_d;
                    if (set_flags_q) begin
                        flags <= hi_status_d;
                    end
                    rsp_valid <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - Scoreboard bench for alu_sequencer with a behavioural operation model
module tb_alu_sequencer;

    localparam int W = 64;

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_fs;
    logic [W-1:0]  req_a, req_b, req_a_hi, req_b_hi;
    logic [1:0]    req_cin_sel;
    logic          req_set_flags, req_wide;
    logic [4:0]    alu_fs;
    logic [W-1:0]  alu_a, alu_b;
    logic          alu_cin;
    logic [W-1:0]  alu_result;
    logic          alu_cout;
    logic [3:0]    alu_status;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_lo, rsp_hi;
    logic [3:0]    rsp_status;
    logic [3:0]    flags;

    alu_sequencer #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_fs(req_fs),
        .req_a(req_a), .req_b(req_b), .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
        .req_cin_sel(req_cin_sel), .req_set_flags(req_set_flags), .req_wide(req_wide),
        .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
        .rsp_status(rsp_status), .flags(flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational ALU: fs[4:2] 0..3 add (fs[1]=1 subtracts), 4 shl1, 5 shr1, 6/7 zero.
    logic [W:0]   stub_s;
    logic [W-1:0] stub_b;
    logic         stub_v;
    always_comb begin
        stub_s = '0;
        stub_b = '0;
        stub_v = 1'b0;
        alu_result = '0;
        alu_cout = 1'b0;
        if (!alu_fs[4]) begin
            stub_b = alu_fs[1] ? ~alu_b : alu_b;
            stub_s = {1'b0, alu_a} + {1'b0, stub_b} + {{W{1'b0}}, alu_cin};
            alu_result = stub_s[W-1:0];
            alu_cout = stub_s[W];
            stub_v = (alu_a[W-1] == stub_b[W-1]) && (stub_s[W-1] != alu_a[W-1]);
        end else if (alu_fs[3:2] == 2'b00) begin
            alu_result = alu_a << 1;
        end else if (alu_fs[3:2] == 2'b01) begin
            alu_result = alu_a >> 1;
        end
        alu_status = {alu_result == '0, alu_result[W-1], alu_cout, stub_v};
    end

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [3:0]   st;
        logic [3:0]   fl;
        int           acc;
        int           lat;
        bit           lat_done;
    } exp_t;

    exp_t     sb[$];
    exp_t     mon_e;
    logic [3:0] model_flags;
    int       cyc;
    int       last_hs;
    int       chk_cnt;
    int       pass_cnt;
    bit       hold_low;
    bit       rand_bp;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Operation meaning: wide operations are one 2W-bit add/subtract.
    function automatic void ref_op(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] ah, input logic [W-1:0] bh, input logic cin,
                                   input logic wide, output logic [W-1:0] lo, output logic [W-1:0] hi,
                                   output logic [3:0] st);
        logic [2*W-1:0] wa, wb;
        logic [2*W:0]   ws;
        logic [W-1:0]   nb, r;
        logic [W:0]     ns;
        lo = '0; hi = '0; st = '0;
        if (fs[4]) begin
            case (fs[3:2])
                2'b00:   r = a << 1;
                2'b01:   r = a >> 1;
                default: r = '0;
            endcase
            lo = r;
            st = {r == '0, r[W-1], 2'b00};
        end else if (wide) begin
            wa = {ah, a};
            wb = fs[1] ? ~{bh, b} : {bh, b};
            ws = {1'b0, wa} + {1'b0, wb} + (2*W+1)'(cin);
            lo = ws[W-1:0];
            hi = ws[2*W-1:W];
            st = {ws[2*W-1:0] == '0, ws[2*W-1], ws[2*W],
                  (wa[2*W-1] == wb[2*W-1]) && (ws[2*W-1] != wa[2*W-1])};
        end else begin
            nb = fs[1] ? ~b : b;
            ns = {1'b0, a} + {1'b0, nb} + (W+1)'(cin);
            lo = ns[W-1:0];
            st = {ns[W-1:0] == '0, ns[W-1], ns[W], (a[W-1] == nb[W-1]) && (ns[W-1] != a[W-1])};
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(posedge clock) begin
        #1;
        rsp_ready = hold_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    always @(negedge clock) begin
        if (reset_n && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 128'(sb.size()), 128'd1);
            end else begin
                mon_e = sb[0];
                if (!mon_e.lat_done) begin
                    chk("latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
                    sb[0].lat_done = 1'b1;
                end
                chk("rsp_lo", 128'(rsp_lo), 128'(mon_e.lo));
                chk("rsp_hi", 128'(rsp_hi), 128'(mon_e.hi));
                chk("rsp_status", 128'(rsp_status), 128'(mon_e.st));
                chk("flags", 128'(flags), 128'(mon_e.fl));
                chk("req_ready_busy", 128'(req_ready), 128'd0);
                if (rsp_ready && !flush) begin
                    last_hs = cyc + 1;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ah, input logic [W-1:0] bh, input logic [1:0] cs,
                         input logic sf, input logic wd, input bit expect_rsp, input bit chk_b2b);
        exp_t e;
        logic cin;
        int   t;
        @(posedge clock);
        #1;
        req_fs = fs; req_a = a; req_b = b; req_a_hi = ah; req_b_hi = bh;
        req_cin_sel = cs; req_set_flags = sf; req_wide = wd; req_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clock);
            if (req_ready) break;
            t++;
            if (t > 300) begin
                chk("accept_timeout", 128'(t), 128'd0);
                req_valid = 1'b0;
                return;
            end
        end
        cin = (cs == 2'b01) ? 1'b1 : (cs == 2'b10) ? model_flags[1] : 1'b0;
        if (expect_rsp) begin
            ref_op(fs, a, b, ah, bh, cin, wd, e.lo, e.hi, e.st);
            if (sf) model_flags = e.st;
            e.fl = model_flags;
            e.acc = cyc + 1;
            e.lat = (wd && !fs[4]) ? 2 : 1;
            e.lat_done = 1'b0;
            sb.push_back(e);
        end
        if (chk_b2b) chk("accept_after_hs", 128'(cyc + 1 - last_hs), 128'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        chk("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready), 128'd1);
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
        chk({tag, "_flags"}, 128'(flags), 128'd0);
        chk({tag, "_rsp_lo"}, 128'(rsp_lo), 128'd0);
        chk({tag, "_rsp_hi"}, 128'(rsp_hi), 128'd0);
        chk({tag, "_rsp_status"}, 128'(rsp_status), 128'd0);
        chk({tag, "_alu"}, {alu_fs, alu_a, alu_b, alu_cin}, 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired chk=%0d", chk_cnt);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ones;
        ones = '1;
        chk_cnt = 0; pass_cnt = 0; model_flags = 4'b0000; last_hs = 0;
        hold_low = 1'b0; rand_bp = 1'b0;
        reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_fs = '0; req_a = '0; req_b = '0; req_a_hi = '0; req_b_hi = '0;
        req_cin_sel = '0; req_set_flags = 1'b0; req_wide = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk_reset_outputs("reset");

        issue(5'b01000, 64'd5, 64'd7, '0, '0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        chk("flags_add", 128'(flags), 128'(4'b0000));
        issue(5'b01010, 64'd5, 64'd5, '0, '0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        chk("flags_sub", 128'(flags), 128'(4'b1010));
        issue(5'b01000, 64'd1, 64'd1, '0, '0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("flags_kept", 128'(flags), 128'(4'b1010));

        issue(5'b01000, ones, 64'd1, '0, '0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        chk("exec_hi_cin", 128'(alu_cin), 128'd1);
        chk("exec_hi_a", 128'(alu_a), 128'd0);
        drain();
        chk("flags_wide", 128'(flags), 128'(4'b0000));

        // Response stall with the next request waiting.
        hold_low = 1'b1;
        issue(5'b01000, 64'd20, 64'd22, '0, '0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        fork
            issue(5'b01010, 64'd9, 64'd3, '0, '0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
            begin
                repeat (6) @(negedge clock);
                hold_low = 1'b0;
            end
        join
        drain();

        // Flush during the upper beat of a wide flag-setting operation.
        issue(5'b01010, 64'd5, 64'd5, '0, '0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        issue(5'b01000, ones, 64'd1, '0, '0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        chk("flush_req_ready", 128'(req_ready), 128'd1);
        chk("flush_flags", 128'(flags), 128'(4'b1010));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("flush_no_rsp", 128'(rsp_valid), 128'd0);
        end

        // Reset during the upper beat.
        issue(5'b01000, ones, 64'd1, 64'd4, 64'd4, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        model_flags = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("reset_no_rsp", 128'(rsp_valid), 128'd0);
        end

        rand_bp = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 5) == 0) ? ones : {$urandom, $urandom};
            rb = ($urandom_range(0, 5) == 0) ? 64'd1 : {$urandom, $urandom};
            issue(5'($urandom), ra, rb, {$urandom, $urandom}, {$urandom, $urandom},
                  2'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
